// File: rtl/layer_seq_if.sv
// Control bundle between the layer sequencer and its surroundings: the input
// and output stream handshakes plus the address/MAC strobes to the datapath.
interface layer_seq_if #(
    parameter int M = 16,
    parameter int N = 12,
    parameter int P = 1
);
    localparam int XW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = ((M / P) * N > 1) ? $clog2((M / P) * N) : 1;
    localparam int SW = (P > 1) ? $clog2(P) : 1;

    logic          s_valid;
    logic          s_ready;
    logic          m_ready;
    logic          m_valid;
    logic          x_wr_en;
    logic [XW-1:0] x_addr;
    logic [WW-1:0] w_addr;
    logic          mac_clr;
    logic          mac_en;
    logic [SW-1:0] out_sel;
    logic          busy;

    // Sequencer side.
    modport master (
        input  s_valid, m_ready,
        output s_ready, m_valid, x_wr_en, x_addr, w_addr,
               mac_clr, mac_en, out_sel, busy
    );

    // Stream source/sink and datapath side.
    modport slave (
        output s_valid, m_ready,
        input  s_ready, m_valid, x_wr_en, x_addr, w_addr,
               mac_clr, mac_en, out_sel, busy
    );
endinterface

// File: rtl/layer_seq_ctrl.sv
// Sequencer for one fully-connected layer: loads an N-word input vector,
// walks M/P groups of N MAC cycles, waits out the MAC pipeline latency and
// drains P results per group. Holds no arithmetic beyond its own counters.
module layer_seq_ctrl #(
    parameter int M       = 16,
    parameter int N       = 12,
    parameter int P       = 1,
    parameter int MAC_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    layer_seq_if.master  ctrl
);
    localparam int G  = M / P;
    localparam int XW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = (G * N > 1) ? $clog2(G * N) : 1;
    localparam int SW = (P > 1) ? $clog2(P) : 1;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int FW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [XW-1:0] K_LAST   = XW'(N - 1);
    localparam logic [GW-1:0] GRP_LAST = GW'(G - 1);
    localparam logic [SW-1:0] OC_LAST  = SW'(P - 1);
    localparam logic [FW-1:0] FL_LAST  = FW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [XW-1:0] r_k;
    logic [GW-1:0] r_grp;
    logic [FW-1:0] r_fl;
    logic [SW-1:0] r_oc;
    logic [WW-1:0] r_w_addr;

    logic w_in_hs;
    logic w_out_hs;

    // Handshakes qualified by state so neither ready/valid depends on the
    // opposite stream's input.
    assign w_in_hs  = (r_state == S_LOAD)  && ctrl.s_valid;
    assign w_out_hs = (r_state == S_DRAIN) && ctrl.m_ready;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and output decode from registered state and counters.
    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        ctrl.s_ready = 1'b0;
        ctrl.m_valid = 1'b0;
        ctrl.x_wr_en = 1'b0;
        ctrl.x_addr  = r_k;
        ctrl.w_addr  = r_w_addr;
        ctrl.mac_clr = 1'b0;
        ctrl.mac_en  = 1'b0;
        ctrl.out_sel = '0;
        ctrl.busy    = 1'b0;
        unique case (r_state)
            S_IDLE: w_state_nxt = S_LOAD;
            S_LOAD: begin
                ctrl.s_ready = 1'b1;
                ctrl.x_wr_en = ctrl.s_valid;
                if (w_in_hs && r_k == K_LAST) w_state_nxt = S_COMPUTE;
            end
            S_COMPUTE: begin
                ctrl.mac_en  = 1'b1;
                ctrl.mac_clr = (r_k == '0);
                ctrl.busy    = 1'b1;
                if (r_k == K_LAST) w_state_nxt = (MAC_LAT == 0) ? S_DRAIN : S_FLUSH;
            end
            S_FLUSH: begin
                ctrl.busy = 1'b1;
                if (r_fl == FL_LAST) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                ctrl.m_valid = 1'b1;
                ctrl.out_sel = r_oc;
                ctrl.busy    = 1'b1;
                if (w_out_hs && r_oc == OC_LAST)
                    w_state_nxt = (r_grp == GRP_LAST) ? S_LOAD : S_COMPUTE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Input index, group, flush, lane and weight-address counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_k      <= '0;
            r_grp    <= '0;
            r_fl     <= '0;
            r_oc     <= '0;
            r_w_addr <= '0;
        end else begin
            unique case (r_state)
                S_LOAD: begin
                    if (w_in_hs) begin
                        if (r_k == K_LAST) begin
                            r_k      <= '0;
                            r_grp    <= '0;
                            r_w_addr <= '0;
                        end else begin
                            r_k <= r_k + XW'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    // Running counter: lands on grp*N+k without a multiplier.
                    r_w_addr <= r_w_addr + WW'(1);
                    if (r_k == K_LAST) begin
                        r_k  <= '0;
                        r_fl <= '0;
                        r_oc <= '0;
                    end else begin
                        r_k <= r_k + XW'(1);
                    end
                end
                S_FLUSH: begin
                    if (r_fl == FL_LAST) begin
                        r_fl <= '0;
                        r_oc <= '0;
                    end else begin
                        r_fl <= r_fl + FW'(1);
                    end
                end
                S_DRAIN: begin
                    if (w_out_hs) begin
                        if (r_oc == OC_LAST) begin
                            r_oc <= '0;
                            if (r_grp == GRP_LAST) begin
                                r_grp <= '0;
                                r_k   <= '0;
                            end else begin
                                r_grp <= r_grp + GW'(1);
                            end
                        end else begin
                            r_oc <= r_oc + SW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Bench for layer_seq_ctrl: two instances (P=1/MAC_LAT=2 and P=4/MAC_LAT=0)
// walked through a schedule built from nested loops over inputs, groups,
// flush cycles and lanes, with randomized stream gating.
module tb_layer_seq_ctrl;
    typedef struct packed {
        logic       s_ready;
        logic       m_valid;
        logic       x_wr_en;
        logic       mac_clr;
        logic       mac_en;
        logic       busy;
        logic [7:0] x_addr;
        logic [7:0] w_addr;
        logic [7:0] out_sel;
    } obs_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic sel   = 1'b0;
    logic sv    = 1'b0;
    logic mr    = 1'b0;
    obs_t obs;

    int n_total = 0;
    int n_bad   = 0;
    int in_cnt  = 0;
    int out_cnt = 0;
    int cM, cN, cP, cL;

    always #5 clk = ~clk;

    layer_seq_if #(.M(16), .N(12), .P(1)) bus_a ();
    layer_seq_if #(.M(16), .N(12), .P(4)) bus_b ();

    layer_seq_ctrl #(.M(16), .N(12), .P(1), .MAC_LAT(2)) dut_a (
        .clk(clk), .reset(reset), .ctrl(bus_a)
    );
    layer_seq_ctrl #(.M(16), .N(12), .P(4), .MAC_LAT(0)) dut_b (
        .clk(clk), .reset(reset), .ctrl(bus_b)
    );

    assign bus_a.s_valid = !sel && sv;
    assign bus_a.m_ready = !sel && mr;
    assign bus_b.s_valid = sel && sv;
    assign bus_b.m_ready = sel && mr;

    always_comb begin
        obs = '0;
        if (!sel) begin
            obs.s_ready = bus_a.s_ready;
            obs.m_valid = bus_a.m_valid;
            obs.x_wr_en = bus_a.x_wr_en;
            obs.mac_clr = bus_a.mac_clr;
            obs.mac_en  = bus_a.mac_en;
            obs.busy    = bus_a.busy;
            obs.x_addr  = 8'(bus_a.x_addr);
            obs.w_addr  = 8'(bus_a.w_addr);
            obs.out_sel = 8'(bus_a.out_sel);
        end else begin
            obs.s_ready = bus_b.s_ready;
            obs.m_valid = bus_b.m_valid;
            obs.x_wr_en = bus_b.x_wr_en;
            obs.mac_clr = bus_b.mac_clr;
            obs.mac_en  = bus_b.mac_en;
            obs.busy    = bus_b.busy;
            obs.x_addr  = 8'(bus_b.x_addr);
            obs.w_addr  = 8'(bus_b.w_addr);
            obs.out_sel = 8'(bus_b.out_sel);
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic obs_t mk(input logic sr, input logic mv, input logic wr,
                                input logic clr, input logic en, input logic bz,
                                input int xa, input int wa, input int os);
        obs_t e;
        e.s_ready = sr;  e.m_valid = mv;  e.x_wr_en = wr;
        e.mac_clr = clr; e.mac_en  = en;  e.busy    = bz;
        e.x_addr  = 8'(xa); e.w_addr = 8'(wa); e.out_sel = 8'(os);
        return e;
    endfunction

    // Fields marked 0 are left unconstrained in that phase.
    function automatic obs_t msk(input bit cx, input bit cw, input bit co);
        obs_t m;
        m = '1;
        if (!cx) m.x_addr  = '0;
        if (!cw) m.w_addr  = '0;
        if (!co) m.out_sel = '0;
        return m;
    endfunction

    function automatic logic coin();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic sample(input string tag, input obs_t e, input obs_t m);
        @(negedge clk);
        check(tag, longint'(obs & m), longint'(e & m));
        if (obs.x_wr_en) in_cnt++;
        if (obs.m_valid && mr) out_cnt++;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Holds reset over three edges, releases it, and leaves the design in LOAD.
    task automatic reset_seq();
        sv    = 1'b0;
        mr    = 1'b0;
        reset = 1'b0;
        repeat (3) begin
            sample("reset", '0, msk(1, 1, 1));
            advance();
        end
        reset = 1'b1;
        sample("idle", '0, msk(1, 1, 1));
        advance();
    endtask

    // One vector: N loads, then per group N MAC cycles, MAC_LAT flush cycles
    // and P drain beats. rnd gates both streams at 50%; bp_grp stalls five
    // drain cycles of that group; ab_g/ab_k fires an async reset mid-compute.
    task automatic run_vector(input bit rnd, input int bp_grp, input int ab_g, input int ab_k);
        int k;
        int stall;
        int bp_left;
        in_cnt  = 0;
        out_cnt = 0;
        bp_left = 5;
        k = 0;
        while (k < cN) begin
            sv = rnd ? coin() : 1'b1;
            mr = coin();
            sample($sformatf("load k%0d", k), mk(1, 0, sv, 0, 0, 0, k, 0, 0), msk(1, 0, 0));
            if (sv) k++;
            advance();
        end
        for (int g = 0; g < cM / cP; g++) begin
            for (int kk = 0; kk < cN; kk++) begin
                sv = coin();
                mr = coin();
                sample($sformatf("compute g%0d k%0d", g, kk),
                       mk(0, 0, 0, kk == 0, 1, 1, kk, g * cN + kk, 0), msk(1, 1, 0));
                if (g == ab_g && kk == ab_k) begin
                    #1 reset = 1'b0;
                    #1 check("async_reset", longint'(obs), 0);
                    return;
                end
                advance();
            end
            for (int f = 0; f < cL; f++) begin
                sv = coin();
                mr = coin();
                sample($sformatf("flush g%0d f%0d", g, f),
                       mk(0, 0, 0, 0, 0, 1, 0, (g + 1) * cN, 0), msk(0, 1, 0));
                advance();
            end
            for (int o = 0; o < cP; o++) begin
                stall = 0;
                do begin
                    sv = coin();
                    if (g == bp_grp && bp_left > 0) begin
                        mr = 1'b0;
                        bp_left--;
                    end else if (rnd && stall < 16) begin
                        mr = coin();
                    end else begin
                        mr = 1'b1;
                    end
                    if (!mr) stall++;
                    sample($sformatf("drain g%0d o%0d", g, o),
                           mk(0, 1, 0, 0, 0, 1, 0, (g + 1) * cN, o), msk(0, 1, 1));
                    advance();
                end while (!mr);
            end
        end
        check("in_handshakes", in_cnt, cN);
        check("out_handshakes", out_cnt, cM);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sel = 1'b0;
        cM = 16; cN = 12; cP = 1; cL = 2;
        reset_seq();
        run_vector(1'b0, -1, -1, -1);   // ungated streams
        run_vector(1'b0, 3, -1, -1);    // downstream stall in group 3
        run_vector(1'b0, -1, 7, 5);     // async reset mid-compute
        reset_seq();
        run_vector(1'b0, -1, -1, -1);   // restart from address 0
        repeat (3) run_vector(1'b1, -1, -1, -1);

        sel = 1'b1;
        cM = 16; cN = 12; cP = 4; cL = 0;
        run_vector(1'b0, -1, -1, -1);
        run_vector(1'b1, -1, -1, -1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
